dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
Two-requester arbiter for the single data memory port (address_dmem / data / wren / q_dmem). It shares that port between the processor (port 0) and the game peripheral engine (port 1), which handles display scan and board rotation. Each requester uses a req/gnt/done handshake. The block sequences each access through a small FSM and returns read data registered. It sits between the requesters and the dmem, which has a synchronous read with 1-cycle latency.

Parameters:
ADDR_W, 10, width of requester word addresses
DEPTH, 1024, number of valid dmem words; word addresses >= DEPTH are out of range

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
req0  in  1  port 0 request; held with we0/addr0/wdata0 stable until gnt0
we0  in  1  port 0 write (1) / read (0)
addr0  in  ADDR_W  port 0 word address
wdata0  in  32  port 0 write data
gnt0  out  1  port 0 request accepted this cycle (combinational)
done0  out  1  port 0 access complete, 1-cycle pulse (registered)
err0  out  1  valid with done0: address was out of range
rdata0  out  32  port 0 read data, valid with done0 on reads
req1, we1, addr1, wdata1, gnt1, done1, err1, rdata1  same as port 0, for port 1
address_dmem  out  32  byte address to dmem, {addr, 2'b00} zero-extended
data  out  32  dmem write data
wren  out  1  dmem write enable
q_dmem  in  32  dmem read data, valid the cycle after address_dmem is presented
busy  out  1  high when the FSM is not in IDLE

Behaviour:
- Reset (async, immediate): FSM=IDLE, rr pointer=port 0. All outputs 0: gnt*, done*, err*, rdata*, address_dmem, data, wren, busy. Any in-flight access is dropped and no done is issued for it.
- FSM states: IDLE, ACCESS, RDWAIT.
- IDLE:
  - If any req is high, select one port. If only one requests, select it. If both request, select the port named by the rr pointer.
  - gnt_sel=1 in this cycle, combinational from state, req and pointer. gnt is never high outside IDLE.
  - At the clock edge: latch we/addr/wdata and the port id, set the rr pointer to the other port, go to ACCESS.
- ACCESS (1 cycle):
  - Drive address_dmem={latched addr,2'b00}, data=latched wdata, wren=latched we.
  - If the address is out of range (addr >= DEPTH): wren forced 0.
  - Write or out of range: next state IDLE; done_sel and err_sel registered high in the following cycle.
  - In-range read: next state RDWAIT.
- RDWAIT (1 cycle):
  - address_dmem is held, wren=0.
  - q_dmem is captured into rdata_sel at the clock edge. Next state IDLE; done_sel=1 in that IDLE cycle.
- Latency from gnt cycle g:
  - write: wren in g+1, done in g+2.
  - read: done and rdata in g+3.
  - A new grant may occur in the same IDLE cycle in which done pulses.
- Out-of-range access: done=1, err=1. Read returns rdata=0. No dmem write occurs.
- rdata_x holds its last value until the next read completion on that port. Writes do not alter rdata.
- Outside ACCESS/RDWAIT: address_dmem=0, data=0, wren=0.
- Fairness: with both ports continuously requesting, grants strictly alternate and no port waits more than one access.
- req dropped before gnt: the request is withdrawn and no access occurs. req changes after gnt are ignored until done.
- done/err are exactly 1-cycle pulses and never assert for both ports in the same cycle.

Test Plan:
- Reset check: assert reset mid-run -> all outputs 0 in the same cycle. After release with req0=req1=0 -> busy=0, wren=0.
- Port 0 write then read: write addr0=5, wdata0=32'hDEADBEEF -> gnt0 at g, address_dmem=32'h14 with wren=1 at g+1, done0 at g+2. Read addr0=5 -> done0 and rdata0=32'hDEADBEEF three cycles after its gnt.
- Simultaneous requests after reset: req0=req1=1, both reads -> gnt0 first, then gnt1 on the next IDLE. Sustained requests -> grant sequence 0,1,0,1 with no repeats.
- Cross-port visibility: port 1 writes addr1=7 with 32'h0000_00A5 while port 0 requests a read of addr 7 -> port 0 read granted after the write, returns 32'h0000_00A5.
- Out of range: addr1=1024 (DEPTH=1024) write -> wren stays 0, done1=1, err1=1, dmem unchanged. Same address as a read -> rdata1=0, err1=1.
- Reset in ACCESS: assert reset while wren=1 -> wren drops immediately and no done follows. After release, with both requesting -> gnt0 granted first.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the single-port data memory between the processor (port 0)
// and the game peripheral engine (port 1); one access in flight, registered completion.
module dmem_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [31:0]       wdata0,
    output logic              gnt0,
    output logic              done0,
    output logic              err0,
    output logic [31:0]       rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [31:0]       wdata1,
    output logic              gnt1,
    output logic              done1,
    output logic              err1,
    output logic [31:0]       rdata1,
    output logic [31:0]       address_dmem,
    output logic [31:0]       data,
    output logic              wren,
    input  logic [31:0]       q_dmem,
    output logic              busy
);

    // state  | meaning
    // IDLE   | no access in flight; grant issued here
    // ACCESS | latched request driven onto the dmem port
    // RDWAIT | address held while the synchronous read returns
    typedef enum logic [1:0] {IDLE, ACCESS, RDWAIT} state_t;

    state_t            state, state_nxt;
    logic              rr_ptr;
    logic              lat_we, lat_port;
    logic [ADDR_W-1:0] lat_addr;
    logic [31:0]       lat_wdata;
    logic              grant_any, grant_port;
    logic              addr_oor, on_port;
    logic              fin, fin_err, fin_rd;
    logic [31:0]       fin_rdata;

    always_comb begin
        state_nxt  = state;
        grant_any  = 1'b0;
        grant_port = 1'b0;
        fin        = 1'b0;
        fin_err    = 1'b0;
        fin_rd     = 1'b0;
        fin_rdata  = 32'h0;
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    grant_any  = 1'b1;
                    grant_port = (req0 && req1) ? rr_ptr : req1;
                    state_nxt  = ACCESS;
                end
            end
            ACCESS: begin
                if (lat_we || addr_oor) begin
                    // out-of-range reads complete here and return zero
                    state_nxt = IDLE;
                    fin       = 1'b1;
                    fin_err   = addr_oor;
                    fin_rd    = ~lat_we;
                end else begin
                    state_nxt = RDWAIT;
                end
            end
            RDWAIT: begin
                state_nxt = IDLE;
                fin       = 1'b1;
                fin_rd    = 1'b1;
                fin_rdata = q_dmem;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // reset must force grants low even though IDLE grants combinationally
    assign gnt0 = grant_any && !grant_port && !reset;
    assign gnt1 = grant_any &&  grant_port && !reset;

    assign busy         = (state != IDLE);
    assign on_port      = (state == ACCESS) || (state == RDWAIT);
    assign addr_oor     = ({{(32-ADDR_W){1'b0}}, lat_addr} >= 32'(DEPTH));
    assign address_dmem = on_port ? {{(30-ADDR_W){1'b0}}, lat_addr, 2'b00} : 32'h0;
    assign data         = on_port ? lat_wdata : 32'h0;
    assign wren         = (state == ACCESS) && lat_we && !addr_oor;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            rr_ptr    <= 1'b0;
            lat_we    <= 1'b0;
            lat_port  <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= 32'h0;
            done0     <= 1'b0;
            done1     <= 1'b0;
            err0      <= 1'b0;
            err1      <= 1'b0;
            rdata0    <= 32'h0;
            rdata1    <= 32'h0;
        end else begin
            state <= state_nxt;
            if (grant_any) begin
                lat_port  <= grant_port;
                lat_we    <= grant_port ? we1 : we0;
                lat_addr  <= grant_port ? addr1 : addr0;
                lat_wdata <= grant_port ? wdata1 : wdata0;
                rr_ptr    <= ~grant_port;
            end
            done0 <= fin && !lat_port;
            done1 <= fin &&  lat_port;
            err0  <= fin_err && !lat_port;
            err1  <= fin_err &&  lat_port;
            if (fin_rd && !lat_port)
                rdata0 <= fin_rdata;
            if (fin_rd && lat_port)
                rdata1 <= fin_rdata;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus random two-port traffic, checked each
// cycle against a transaction-level model of grant order, timing and memory contents.
module tb_dmem_arbiter;

    localparam int AW    = 11;
    localparam int DEPTH = 1024;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [31:0]   wdata0 = 32'h0, wdata1 = 32'h0;
    logic          gnt0, done0, err0, gnt1, done1, err1, wren, busy;
    logic [31:0]   rdata0, rdata1, address_dmem, data;
    logic [31:0]   q_dmem = 32'h0;

    always #5 clock = ~clock;

    dmem_arbiter #(.ADDR_W(AW), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0), .done0(done0), .err0(err0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1), .done1(done1), .err1(err1), .rdata1(rdata1),
        .address_dmem(address_dmem), .data(data), .wren(wren),
        .q_dmem(q_dmem), .busy(busy)
    );

    function automatic logic [31:0] init_word(int i);
        return (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_0000;
    endfunction

    // dmem with 1-cycle synchronous read
    logic [31:0] mem [0:1023];
    logic        mem_ready = 1'b0;
    always @(posedge clock) begin
        if (!mem_ready) begin
            for (int i = 0; i < 1024; i++) mem[i] <= init_word(i);
            mem_ready <= 1'b1;
        end else if (wren) begin
            mem[address_dmem[11:2]] <= data;
        end
        q_dmem <= mem[address_dmem[11:2]];
    end

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    task automatic check_outputs_zero(input string tag);
        check_val({tag, "_gnt"},  {30'h0, gnt1, gnt0}, 32'h0);
        check_val({tag, "_done"}, {30'h0, done1, done0}, 32'h0);
        check_val({tag, "_err"},  {30'h0, err1, err0}, 32'h0);
        check_val({tag, "_rd0"},  rdata0, 32'h0);
        check_val({tag, "_rd1"},  rdata1, 32'h0);
        check_val({tag, "_addr"}, address_dmem, 32'h0);
        check_val({tag, "_data"}, data, 32'h0);
        check_val({tag, "_wren_busy"}, {30'h0, wren, busy}, 32'h0);
    endtask

    // Reference model: one access at a time; a grant occupies the port for 2 cycles
    // (write / out of range) or 3 cycles (read), done pulses on the first free cycle.
    logic        gs0 = 1'b0, gs1 = 1'b0;
    logic        m_active = 1'b0, m_port = 1'b0, m_we = 1'b0, m_oor = 1'b0, m_rr = 1'b0;
    int          m_g = 0, m_done_c = 0, m_addr = 0;
    logic [31:0] m_wdata = 32'h0;
    logic [31:0] m_rd [2];
    logic [31:0] ref_mem [0:1023];
    bit          ref_init = 1'b0;

    always @(negedge clock) begin : monitor
        int   sel;
        logic busy_e, acc, rdw, fin_e;
        if (reset) begin
            if (!ref_init) begin
                for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
                ref_init = 1'b1;
            end
            check_outputs_zero("in_reset");
            m_active = 1'b0;
            m_rr = 1'b0;
            m_rd[0] = 32'h0;
            m_rd[1] = 32'h0;
            gs0 = 1'b0;
            gs1 = 1'b0;
        end else begin
            busy_e = m_active && (cyc < m_done_c);
            acc    = m_active && (cyc == m_g + 1);
            rdw    = m_active && (cyc == m_g + 2) && !m_we && !m_oor;
            fin_e  = m_active && (cyc == m_done_c);
            if (fin_e && !m_we) m_rd[m_port] = m_oor ? 32'h0 : ref_mem[m_addr];
            check_val("busy",  busy, busy_e);
            check_val("done0", done0, fin_e && !m_port);
            check_val("done1", done1, fin_e && m_port);
            check_val("err0",  err0, fin_e && !m_port && m_oor);
            check_val("err1",  err1, fin_e && m_port && m_oor);
            check_val("rdata0", rdata0, m_rd[0]);
            check_val("rdata1", rdata1, m_rd[1]);
            check_val("wren", wren, acc && m_we && !m_oor);
            check_val("address_dmem", address_dmem, (acc || rdw) ? 32'(m_addr * 4) : 32'h0);
            if (acc) check_val("data", data, m_wdata);
            else if (!rdw) check_val("data_idle", data, 32'h0);
            if (acc && m_we && !m_oor) ref_mem[m_addr] = m_wdata;
            sel = -1;
            if (!busy_e) begin
                if (req0 && req1) sel = int'(m_rr);
                else if (req0) sel = 0;
                else if (req1) sel = 1;
            end
            check_val("gnt0", gnt0, sel == 0);
            check_val("gnt1", gnt1, sel == 1);
            gs0 = gnt0;
            gs1 = gnt1;
            if (sel >= 0) begin
                m_active = 1'b1;
                m_g      = cyc;
                m_port   = (sel == 1);
                m_we     = m_port ? we1 : we0;
                m_addr   = m_port ? int'(addr1) : int'(addr0);
                m_wdata  = m_port ? wdata1 : wdata0;
                m_oor    = (m_addr >= DEPTH);
                m_done_c = cyc + ((m_we || m_oor) ? 2 : 3);
                m_rr     = (sel == 0);
            end
        end
        cyc++;
    end

    task automatic set_port(input int p, input logic r, input logic w,
                            input logic [AW-1:0] a, input logic [31:0] d);
        if (p == 0) begin req0 = r; we0 = w; addr0 = a; wdata0 = d; end
        else        begin req1 = r; we1 = w; addr1 = a; wdata1 = d; end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic do_req(input int p, input logic w, input logic [AW-1:0] a, input logic [31:0] d);
        logic got;
        got = 1'b0;
        @(posedge clock); #1;
        set_port(p, 1'b1, w, a, d);
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge clock); #1;
            got = (p == 0) ? gs0 : gs1;
        end
        check_val("gnt_wait", got, 1'b1);
        @(posedge clock); #1;
        set_port(p, 1'b0, w, a, d);
    endtask

    task automatic do_both(input logic w0, input logic [AW-1:0] a0, input logic [31:0] d0,
                           input logic w1, input logic [AW-1:0] a1, input logic [31:0] d1,
                           input int exp_first);
        logic got0, got1;
        int   first;
        got0 = 1'b0; got1 = 1'b0; first = -1;
        @(posedge clock); #1;
        set_port(0, 1'b1, w0, a0, d0);
        set_port(1, 1'b1, w1, a1, d1);
        for (int k = 0; k < 50 && !(got0 && got1); k++) begin
            @(negedge clock); #1;
            if (gs0 && !got0) begin got0 = 1'b1; if (first < 0) first = 0; end
            if (gs1 && !got1) begin got1 = 1'b1; if (first < 0) first = 1; end
            @(posedge clock); #1;
            if (got0) req0 = 1'b0;
            if (got1) req1 = 1'b0;
        end
        req0 = 1'b0;
        req1 = 1'b0;
        check_val("both_granted", {got1, got0}, 2'b11);
        check_val("first_gnt", first, exp_first);
    endtask

    initial begin : stimulus
        logic          po [2];
        logic          pw [2];
        logic [AW-1:0] pa [2];
        logic [31:0]   pd [2];
        logic          g;

        wait_cycles(3);
        reset = 1'b0;
        wait_cycles(2);

        // simultaneous reads right after reset: port 0 wins
        do_both(1'b0, 11'd3, 32'h0, 1'b0, 11'd4, 32'h0, 0);
        wait_cycles(4);

        do_req(0, 1'b1, 11'd5, 32'hDEAD_BEEF);
        wait_cycles(3);
        do_req(0, 1'b0, 11'd5, 32'h0);
        wait_cycles(4);
        check_val("rd_deadbeef", rdata0, 32'hDEAD_BEEF);

        // port 1 write and port 0 read of the same word; pointer favours port 1 now
        do_both(1'b0, 11'd7, 32'h0, 1'b1, 11'd7, 32'h0000_00A5, 1);
        wait_cycles(5);
        check_val("rd_cross", rdata0, 32'h0000_00A5);

        do_req(1, 1'b1, 11'd1024, 32'hFFFF_FFFF);
        wait_cycles(3);
        check_val("oor_nowrite", mem[0], init_word(0));
        do_req(1, 1'b0, 11'd1024, 32'h0);
        wait_cycles(4);
        check_val("oor_rdata", rdata1, 32'h0);

        // reset while a write is on the dmem port
        @(posedge clock); #1;
        set_port(0, 1'b1, 1'b1, 11'd9, 32'h1234_5678);
        g = 1'b0;
        for (int k = 0; k < 20 && !g; k++) begin
            @(negedge clock); #1;
            g = gs0;
        end
        check_val("rst_gnt_wait", g, 1'b1);
        @(posedge clock); #1;
        req0 = 1'b0;
        check_val("wren_pre_reset", wren, 1'b1);
        #1 reset = 1'b1;
        #1 check_outputs_zero("rst_immediate");
        wait_cycles(2);
        reset = 1'b0;
        do_both(1'b0, 11'd9, 32'h0, 1'b0, 11'd10, 32'h0, 0);
        wait_cycles(4);
        check_val("rst_nowrite", mem[9], init_word(9));

        // random two-port traffic
        for (int p = 0; p < 2; p++) begin po[p] = 1'b0; pw[p] = 1'b0; pa[p] = '0; pd[p] = 32'h0; end
        for (int c = 0; c < 1500; c++) begin
            @(posedge clock); #1;
            for (int p = 0; p < 2; p++) begin
                g = (p == 0) ? gs0 : gs1;
                if (po[p] && g) po[p] = 1'b0;
                else if (po[p] && $urandom_range(15) == 0) po[p] = 1'b0;
                if (!po[p] && $urandom_range(3) != 0) begin
                    po[p] = 1'b1;
                    pw[p] = 1'($urandom_range(1));
                    pa[p] = ($urandom_range(7) == 0) ? AW'(1024 + $urandom_range(1023))
                                                     : AW'($urandom_range(31));
                    pd[p] = $urandom;
                end
                set_port(p, po[p], pw[p], pa[p], pd[p]);
            end
        end
        @(posedge clock); #1;
        req0 = 1'b0;
        req1 = 1'b0;
        wait_cycles(10);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
